// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int CNT_WIDTH = 6;

    // Counter value on the cycle that performs the final iteration.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DIV_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SIGN = 2'd2
    } div_state_t;

    // Two's complement magnitude. The most negative value maps onto itself,
    // which is the correct unsigned magnitude 2^(DIV_WIDTH-1).
    function automatic logic [DIV_WIDTH-1:0] magnitude(input logic [DIV_WIDTH-1:0] v,
                                                       input logic               is_neg);
        return is_neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift in a dividend bit, trial-subtract the divisor.
// Latency: purely combinational.
// Backpressure: none.
module div_step
    import div_pkg::*;
(
    input  logic [DIV_WIDTH-1:0] rem_in,
    input  logic                 dividend_bit,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic [DIV_WIDTH-1:0] rem_out,
    output logic                 q_bit
);

    logic [DIV_WIDTH:0] shifted;
    logic [DIV_WIDTH:0] diff;

    // rem_in < divisor always holds, so shifted < 2*divisor: a non-negative
    // difference fits in DIV_WIDTH bits and the top bit is a pure borrow.
    assign shifted = {rem_in, dividend_bit};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = ~diff[DIV_WIDTH];
    assign rem_out = q_bit ? diff[DIV_WIDTH-1:0] : shifted[DIV_WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Sequential 32-bit signed divider (optional unsigned mode via DIV_UNIT_DIVU_EN).
// Latency: 34 edges from accepted divOp to done; divide-by-zero reports done after 1 edge.
// Backpressure: divOp is ignored while busy; a new divOp is accepted in the done cycle.
module div_unit
    import div_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 divOp,
`ifdef DIV_UNIT_DIVU_EN
    input  logic                 divu,
`endif
    input  logic [DIV_WIDTH-1:0] dividend,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic [DIV_WIDTH-1:0] div_hi,
    output logic [DIV_WIDTH-1:0] div_lo,
    output logic                 divby0flag,
    output logic                 busy,
    output logic                 done
);

    div_state_t           state;
    div_state_t           state_nxt;
    logic [CNT_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] rem;       // partial remainder
    logic [DIV_WIDTH-1:0] quo;       // dividend bits shift out, quotient bits shift in
    logic [DIV_WIDTH-1:0] dvsr;      // divisor magnitude
    logic                 neg_quo;   // operand signs differ
    logic                 neg_rem;   // dividend negative

    logic                 op_signed;
    logic                 sign_a;
    logic                 sign_b;
    logic                 div_zero;
    logic [DIV_WIDTH-1:0] rem_step;
    logic                 q_bit;

`ifdef DIV_UNIT_DIVU_EN
    assign op_signed = ~divu;
`else
    assign op_signed = 1'b1;
`endif

    // Unsigned operation treats both operands as non-negative, so no abs
    // and no sign fix-up happen; the timing is unchanged.
    assign sign_a   = op_signed & dividend[DIV_WIDTH-1];
    assign sign_b   = op_signed & divisor[DIV_WIDTH-1];
    assign div_zero = (divisor == '0);
    assign busy     = (state != ST_IDLE);

    div_step u_step (
        .rem_in       (rem),
        .dividend_bit (quo[DIV_WIDTH-1]),
        .divisor      (dvsr),
        .rem_out      (rem_step),
        .q_bit        (q_bit)
    );

    // Next-state: start only on a non-zero divisor, 32 iterations, then one fix-up cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (divOp && !div_zero) state_nxt = ST_RUN;
            ST_RUN:  if (cnt == CNT_LAST)    state_nxt = ST_SIGN;
            ST_SIGN: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register plus datapath: operand capture, iteration, and result write-back.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            rem        <= '0;
            quo        <= '0;
            dvsr       <= '0;
            neg_quo    <= 1'b0;
            neg_rem    <= 1'b0;
            div_hi     <= '0;
            div_lo     <= '0;
            divby0flag <= 1'b0;
            done       <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (divOp) begin
                        divby0flag <= div_zero;
                        if (div_zero) begin
                            // Exception completes immediately; results keep old values.
                            done <= 1'b1;
                        end else begin
                            quo     <= magnitude(dividend, sign_a);
                            dvsr    <= magnitude(divisor, sign_b);
                            neg_quo <= sign_a ^ sign_b;
                            neg_rem <= sign_a;
                            rem     <= '0;
                            cnt     <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    rem <= rem_step;
                    quo <= {quo[DIV_WIDTH-2:0], q_bit};
                    cnt <= cnt + 1'b1;
                end
                ST_SIGN: begin
                    div_lo <= neg_quo ? (~quo + 1'b1) : quo;
                    div_hi <= neg_rem ? (~rem + 1'b1) : rem;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized operations.
// Latency: checks 34-edge completion and 1-edge divide-by-zero completion.
// Backpressure: exercises ignored divOp while busy and back-to-back starts.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        div_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] div_hi;
    logic [31:0] div_lo;
    logic        divby0flag;
    logic        busy;
    logic        done;
`ifdef DIV_UNIT_DIVU_EN
    logic        divu_s;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state of the architectural outputs.
    logic [31:0] exp_hi   = '0;
    logic [31:0] exp_lo   = '0;
    logic [31:0] exp_flag = '0;

    div_unit dut (
        .clk        (clk),
        .reset      (reset),
        .divOp      (div_op),
`ifdef DIV_UNIT_DIVU_EN
        .divu       (divu_s),
`endif
        .dividend   (dividend),
        .divisor    (divisor),
        .div_hi     (div_hi),
        .div_lo     (div_lo),
        .divby0flag (divby0flag),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behavioural model: plain 64-bit arithmetic, C-style truncating division.
    task automatic model_apply(input logic [31:0] a, input logic [31:0] b, input logic u);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) begin
            exp_flag = 32'd1;
        end else begin
            exp_flag = 32'd0;
            if (u) begin
                sa = longint'({32'd0, a});
                sb = longint'({32'd0, b});
            end else begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end
            q = sa / sb;
            r = sa % sb;
            exp_lo = q[31:0];
            exp_hi = r[31:0];
        end
    endtask

    // Starts an operation at a negedge and returns at the negedge where done is seen.
    // glitch > 0 pulses a second divOp (1/1) that many edges after the start edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic u,
                          input int glitch);
        int          edges;
        logic [31:0] old_lo;
        old_lo   = exp_lo;
        dividend = a;
        divisor  = b;
`ifdef DIV_UNIT_DIVU_EN
        divu_s   = u;
`endif
        div_op   = 1'b1;
        @(negedge clk);
        div_op = 1'b0;
        model_apply(a, b, u);
        check("busy_after_start", 32'(busy), 32'(b != 32'd0));
        check("done_after_start", 32'(done), 32'(b == 32'd0));
        edges = 1;
        while (!done && edges < 100) begin
            if (edges == glitch) begin
                div_op   = 1'b1;
                dividend = 32'd1;
                divisor  = 32'd1;
                check("hold_lo_mid_run", div_lo, old_lo);
            end
            @(negedge clk);
            div_op = 1'b0;
            edges++;
        end
        check("latency", 32'(edges), (b == 32'd0) ? 32'd1 : 32'd34);
        check("div_lo", div_lo, exp_lo);
        check("div_hi", div_hi, exp_hi);
        check("divby0flag", 32'(divby0flag), exp_flag);
        check("busy_in_done", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        ru;
        reset    = 1'b1;
        div_op   = 1'b0;
        dividend = '0;
        divisor  = '0;
`ifdef DIV_UNIT_DIVU_EN
        divu_s   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_hi", div_hi, 32'd0);
        check("rst_lo", div_lo, 32'd0);
        check("rst_flag", 32'(divby0flag), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 7 / 2 and -7 / 2
        run_op(32'd7, 32'd2, 1'b0, 0);
        check("7div2_lo", div_lo, 32'd3);
        check("7div2_hi", div_hi, 32'd1);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 0);
        check("m7div2_lo", div_lo, 32'hFFFF_FFFD);
        check("m7div2_hi", div_hi, 32'hFFFF_FFFF);

        // Preload, divide by zero keeps results, then a normal op clears the flag.
        run_op(32'd9, 32'd4, 1'b0, 0);
        run_op(32'd5, 32'd0, 1'b0, 0);
        check("dz_hi_kept", div_hi, 32'd1);
        check("dz_lo_kept", div_lo, 32'd2);
        check("dz_flag", 32'(divby0flag), 32'd1);
        @(negedge clk);
        check("dz_flag_held", 32'(divby0flag), 32'd1);
        check("dz_done_pulse", 32'(done), 32'd0);
        run_op(32'd9, 32'd3, 1'b0, 0);
        check("9div3_flag", 32'(divby0flag), 32'd0);
        check("9div3_lo", div_lo, 32'd3);

        // Overflow wrap case.
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        check("ovf_lo", div_lo, 32'h8000_0000);
        check("ovf_hi", div_hi, 32'd0);

        // Ignored divOp mid-run.
        run_op(32'd100, 32'd7, 1'b0, 5);
        check("100div7_lo", div_lo, 32'd14);
        check("100div7_hi", div_hi, 32'd2);

        // Reset mid-operation, with a simultaneous divOp.
        dividend = 32'd1234567;
        divisor  = 32'd89;
        div_op   = 1'b1;
        @(negedge clk);
        div_op = 1'b0;
        repeat (9) @(negedge clk);
        reset  = 1'b1;
        div_op = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        div_op = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_hi", div_hi, 32'd0);
        check("midrst_lo", div_lo, 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        exp_hi   = '0;
        exp_lo   = '0;
        exp_flag = '0;
        @(negedge clk);
        check("midrst_idle", 32'(busy), 32'd0);

`ifdef DIV_UNIT_DIVU_EN
        run_op(32'hFFFF_FFFE, 32'd2, 1'b1, 0);
        check("divu_lo", div_lo, 32'h7FFF_FFFF);
        check("divu_hi", div_hi, 32'd0);
        run_op(32'hFFFF_FFFE, 32'd2, 1'b0, 0);
        check("div_s_lo", div_lo, 32'hFFFF_FFFF);
        check("div_s_hi", div_hi, 32'd0);
`endif

        // Randomized, back-to-back operations (each starts in the previous done cycle).
        for (int i = 0; i < 150; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = -$urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
`ifdef DIV_UNIT_DIVU_EN
            ru = 1'($urandom_range(0, 1));
`else
            ru = 1'b0;
`endif
            run_op(ra, rb, ru, ($urandom_range(0, 3) == 0) ? $urandom_range(2, 30) : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: divOp  input  1  start request; sampled only in IDLE.
REQ-004 SHALL have port: dividend  input  32  numerator; two's complement.
REQ-005 SHALL have port: divisor  input  32  denominator; two's complement.
REQ-006 SHALL have port: div_hi  output  32  remainder; registered.
REQ-007 SHALL have port: div_lo  output  32  quotient; registered.
REQ-008 SHALL have port: divby0flag  output  1  divide-by-zero exception flag; registered.
REQ-009 SHALL have port: busy  output  1  high while in RUN or SIGN.
REQ-010 SHALL have port: done  output  1  one-cycle pulse; result or exception valid.

Function
REQ-011 SHALL implement states IDLE, RUN, SIGN; transitions are IDLE->RUN on divOp with divisor!=0, RUN->SIGN after 32nd iteration, SIGN->IDLE unconditionally.
REQ-012 SHALL, on edge E0 with IDLE and divOp=1, latch |dividend|, |divisor|, both sign bits, and clear the 6-bit iteration counter.
REQ-013 SHALL perform one restoring shift-subtract iteration per RUN cycle, on edges E1..E32, producing one quotient bit per edge, MSB first.
REQ-014 SHALL, on edge E33 (SIGN), write div_lo = quotient, negated if the operand signs differ.
REQ-015 SHALL, on edge E33 (SIGN), write div_hi = remainder, negated if the dividend is negative, and set done=1 for exactly one cycle.
REQ-016 SHALL give a fixed latency of 34 edges from start to done, with results visible in the same cycle as done.
REQ-017 SHALL, on edge E0 with divisor==0, stay in IDLE, set divby0flag=1 and done=1 for one cycle, and leave div_hi and div_lo unchanged.
REQ-018 SHALL hold divby0flag until the next accepted divOp, which clears it.
REQ-019 SHALL ignore divOp while busy=1, with no restart and no change to the latched operands.
REQ-020 SHALL produce div_lo=0x80000000 and div_hi=0 for 0x80000000 / 0xFFFFFFFF (wrap, no exception).
REQ-021 SHALL hold div_hi and div_lo stable outside SIGN-edge updates.
REQ-022 SHALL accept a back-to-back divOp in the IDLE cycle in which done is high.

Reset
REQ-023 SHALL, on reset=1 at any edge including mid-operation, force IDLE and set div_hi=0, div_lo=0, divby0flag=0, busy=0, done=0, counter=0.
REQ-024 SHALL give reset priority over divOp in the same cycle.

Configuration
REQ-025 SHALL, with DIV_UNIT_DIVU_EN defined, add input divu (1 bit); divu=1 sampled at start selects unsigned division, skipping the abs and sign fix-up steps, with identical latency.
REQ-026 SHALL, without DIV_UNIT_DIVU_EN, omit the divu port and always perform signed division.

Structure
REQ-027 SHALL place the state enum, DIV_WIDTH=32, and the counter width constant in shared package div_pkg.
REQ-028 SHALL implement one iteration as combinational sub-module div_step (inputs: partial remainder, dividend bit, divisor; outputs: next remainder, quotient bit).

Verification
REQ-029 SHALL test: 7 / 2 -> done at edge E33, div_lo=3, div_hi=1, divby0flag=0.
REQ-030 SHALL test: -7 / 2 -> div_lo=0xFFFFFFFD, div_hi=0xFFFFFFFF.
REQ-031 SHALL test: preload results, then 5 / 0 -> done one cycle after start, divby0flag=1, div_hi and div_lo unchanged; then 9 / 3 -> divby0flag=0, div_lo=3, div_hi=0.
REQ-032 SHALL test: 0x80000000 / 0xFFFFFFFF -> div_lo=0x80000000, div_hi=0, divby0flag=0.
REQ-033 SHALL test: 100 / 7 started, second divOp with 1 / 1 at RUN cycle 5, reset at a later run's cycle 10 -> first run completes with div_lo=14 and div_hi=2; after reset, busy=0 and div_hi=div_lo=0.
REQ-034 SHALL test, with DIV_UNIT_DIVU_EN: 0xFFFFFFFE / 2 with divu=1 -> div_lo=0x7FFFFFFF, div_hi=0; same operands with divu=0 -> div_lo=0xFFFFFFFF, div_hi=0.
